// File: rtl/fc_layer_engine.sv
// fc_layer_engine: NUM_NEURONS parallel MACs over a streamed IFM_DEPTH vector, then bias, scale/saturate, optional ReLU.
// Latency: start -> in_ready next cycle; last input handshake at cycle T -> out_valid at T+3.
// Backpressure: in_ready only while RUN; out_data/out_valid held until out_ready, engine stays busy meanwhile.
module fc_layer_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int IFM_DEPTH    = 80,
  parameter int NUM_NEURONS  = 10,
  parameter int FRAC_BITS    = 8,
  parameter int ADDRESS_BITS = 15,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(IFM_DEPTH) + 1,
  parameter bit RELU_IN      = 1,
  parameter bit RELU_OUT     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             riscv_data,
  input  logic [ADDRESS_BITS-1:0]           riscv_address,
  input  logic [NUM_NEURONS-1:0]            wm_enable_write,
  input  logic [NUM_NEURONS-1:0]            bm_enable_write,
  input  logic                              start,
  output logic                              busy,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
  output logic                              done
);

  localparam int IDX_W  = $clog2(IFM_DEPTH);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(IFM_DEPTH - 1);
  localparam logic [ADDRESS_BITS-1:0] DEPTH_A  = ADDRESS_BITS'(IFM_DEPTH);
  // Saturation bounds of the output format, expressed in accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                          hs;
  logic                          cfg_en;
  logic                          addr_ok;
  logic                          start_acc;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              mem_addr;
  logic signed [DATA_WIDTH-1:0]  in_relu;
  logic signed [DATA_WIDTH-1:0]  x_reg;
  logic                          mac_v;

  logic signed [DATA_WIDTH-1:0]  wmem       [NUM_NEURONS][IFM_DEPTH];
  logic signed [DATA_WIDTH-1:0]  w_q        [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]  bias_q     [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   acc_q      [NUM_NEURONS];
  logic signed [PROD_W-1:0]      prod       [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   prod_ext   [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   bias_ext   [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   acc_biased [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]   scaled     [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]         res        [NUM_NEURONS];

  // Config writes only land while idle; out-of-range weight addresses are dropped
  assign cfg_en    = (state_q == S_IDLE);
  assign addr_ok   = (riscv_address < DEPTH_A);
  assign start_acc = cfg_en && start;
  assign hs        = in_valid && (state_q == S_RUN);
  // Single memory port: config address while idle, sample index otherwise
  assign mem_addr  = cfg_en ? riscv_address[IDX_W-1:0] : idx;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and status outputs decoded from the current state
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && (idx == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_BIAS;
      S_BIAS:  state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Optional ReLU on each incoming sample before it is registered
  always_comb begin
    in_relu = $signed(in_data);
    if (RELU_IN && in_data[DATA_WIDTH-1]) in_relu = '0;
  end

  // Weight memories: written from config while idle, read every cycle with one-cycle latency
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (cfg_en && addr_ok && wm_enable_write[n]) wmem[n][mem_addr] <= $signed(riscv_data);
      w_q[n] <= wmem[n][mem_addr];
    end
  end

  // Per-neuron arithmetic: product, bias alignment, scaling, saturation and output ReLU
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      // Low PROD_W bits of the product of sign-extended operands equal the signed product
      prod[n]       = $signed({{DATA_WIDTH{x_reg[DATA_WIDTH-1]}}, x_reg}) *
                      $signed({{DATA_WIDTH{w_q[n][DATA_WIDTH-1]}}, w_q[n]});
      prod_ext[n]   = {{(ACC_WIDTH-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
      bias_ext[n]   = {{(ACC_WIDTH-DATA_WIDTH){bias_q[n][DATA_WIDTH-1]}}, bias_q[n]} <<< FRAC_BITS;
      acc_biased[n] = acc_q[n] + bias_ext[n];
      scaled[n]     = acc_biased[n] >>> FRAC_BITS;
      if (scaled[n] > SAT_MAX)      res[n] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (scaled[n] < SAT_MIN) res[n] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                          res[n] = scaled[n][DATA_WIDTH-1:0];
      if (RELU_OUT && res[n][DATA_WIDTH-1]) res[n] = '0;
    end
  end

  // Sample index, input register and MAC-valid pipeline flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      x_reg <= '0;
      mac_v <= 1'b0;
    end else begin
      mac_v <= hs;
      if (start_acc) idx <= '0;
      else if (hs)   idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (hs) x_reg <= in_relu;
    end
  end

  // Accumulators, bias registers and the held result; done marks the first out_valid cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      out_data <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        acc_q[n]  <= '0;
        bias_q[n] <= '0;
      end
    end else begin
      done <= (state_q == S_BIAS);
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (cfg_en && bm_enable_write[n]) bias_q[n] <= $signed(riscv_data);
        if (start_acc) begin
          acc_q[n] <= '0;
        end else if (mac_v) begin
          acc_q[n] <= acc_q[n] + prod_ext[n];
        end else if (state_q == S_BIAS) begin
          acc_q[n] <= acc_biased[n];
          out_data[n*DATA_WIDTH +: DATA_WIDTH] <= res[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: two engine configurations on shared stimulus, scoreboarded against a arithmetic model.
// Latency: checks start->in_ready of one cycle and last handshake->out_valid of three cycles.
// Backpressure: randomized in_valid gaps and out_ready holds, with stray start/config pulses while busy.
module tb_fc_layer_engine;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NN    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] riscv_data;
  logic [14:0]   riscv_address;
  logic [NN-1:0] wm_enable_write, bm_enable_write;
  logic          start, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          busy_a, in_ready_a, out_valid_a, done_a;
  logic          busy_b, in_ready_b, out_valid_b, done_b;
  logic [NN*DW-1:0] out_data_a, out_data_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -100;
  int w_m [NN][DEPTH];
  int b_m [NN];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pv[2];
  logic [31:0] pd[2];
  logic        bchk[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fc_layer_engine #(.DATA_WIDTH(DW), .IFM_DEPTH(DEPTH), .NUM_NEURONS(NN), .FRAC_BITS(0),
                    .ADDRESS_BITS(15), .RELU_IN(1), .RELU_OUT(0)) dut_a (
    .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
    .wm_enable_write(wm_enable_write), .bm_enable_write(bm_enable_write), .start(start),
    .busy(busy_a), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .done(done_a));

  fc_layer_engine #(.DATA_WIDTH(DW), .IFM_DEPTH(DEPTH), .NUM_NEURONS(NN), .FRAC_BITS(4),
                    .ADDRESS_BITS(15), .RELU_IN(0), .RELU_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
    .wm_enable_write(wm_enable_write), .bm_enable_write(bm_enable_write), .start(start),
    .busy(busy_b), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .done(done_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: dot product, bias scaled into the fixed-point grid, floor shift, clamp, ReLUs
  function automatic logic [31:0] model(input int x[DEPTH], input int frac, input bit rin, input bit rout);
    logic [31:0] r;
    longint acc, xi;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int i = 0; i < DEPTH; i++) begin
        xi = x[i];
        if (rin && xi < 0) xi = 0;
        acc += xi * longint'(w_m[n][i]);
      end
      acc += longint'(b_m[n]) * (longint'(1) << frac);
      acc = acc >>> frac;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      if (rout && acc < 0) acc = 0;
      r[n*DW +: DW] = acc[15:0];
    end
    return r;
  endfunction

  task automatic mon(input int d, input logic ov, input logic dn, input logic bz, input logic [31:0] od);
    logic [31:0] e;
    int sz;
    if (bchk[d]) check($sformatf("busy_drop%0d", d), bz, 0);
    bchk[d] = 1'b0;
    if (ov) begin
      if (!pv[d]) begin
        check($sformatf("done_first%0d", d), dn, 1);
        check($sformatf("latency%0d", d), cyc - last_hs, 3);
      end else begin
        check($sformatf("done_once%0d", d), dn, 0);
        check($sformatf("hold%0d", d), od, pd[d]);
      end
      if (out_ready) begin
        sz = (d == 0) ? q0.size() : q1.size();
        check($sformatf("sb_nonempty%0d", d), sz > 0, 1);
        if (sz > 0) begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("out_data%0d", d), od, e);
        end
        bchk[d] = 1'b1;
      end
    end else begin
      check($sformatf("done_idle%0d", d), dn, 0);
    end
    pv[d] = ov;
    pd[d] = od;
  endtask

  // Monitor: independent of stimulus, compares each presented result to the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        pv[d] = 1'b0;
        bchk[d] = 1'b0;
      end
    end else begin
      if (in_valid && in_ready_a) last_hs = cyc;
      mon(0, out_valid_a, done_a, busy_a, out_data_a);
      mon(1, out_valid_b, done_b, busy_b, out_data_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_w(input int n, input int addr, input int data);
    riscv_address = 15'(addr);
    riscv_data = 16'(data);
    wm_enable_write = '0;
    wm_enable_write[n] = 1'b1;
    tick();
    wm_enable_write = '0;
    if (addr < DEPTH) w_m[n][addr] = data;
  endtask

  task automatic cfg_b(input int n, input int data);
    riscv_data = 16'(data);
    bm_enable_write = '0;
    bm_enable_write[n] = 1'b1;
    tick();
    bm_enable_write = '0;
    b_m[n] = data;
  endtask

  task automatic load_s1();
    for (int i = 0; i < DEPTH; i++) begin
      cfg_w(0, i, i + 1);
      cfg_w(1, i, -1);
    end
    cfg_b(0, 10);
    cfg_b(1, 5);
  endtask

  task automatic run_vec(input int x[DEPTH], input int gap_pct, input int hold,
                         input bit noisy, input bit use_pat, input logic [6:0] pat);
    int k, j, guard;
    logic v, rdy;
    q0.push_back(model(x, 0, 1'b1, 1'b0));
    q1.push_back(model(x, 4, 1'b0, 1'b1));
    start = 1'b1;
    check("rdy_at_start", in_ready_a, 0);
    tick();
    start = 1'b0;
    check("rdy_after_start", in_ready_a, 1);
    check("busy_after_start", busy_a, 1);
    k = 0; j = 0; guard = 0;
    while (k < DEPTH && guard < 200) begin
      v = (use_pat && j < 7) ? pat[j] : ($urandom_range(99) >= 32'(gap_pct));
      in_valid = v;
      in_data = 16'(x[k]);
      if (noisy) begin
        start = 1'($urandom_range(1));
        riscv_address = '0;
        riscv_data = j[0] ? 16'd99 : 16'd100;
        wm_enable_write = j[0] ? 2'b00 : 2'b01;
        bm_enable_write = j[0] ? 2'b01 : 2'b00;
      end
      rdy = in_ready_a;
      tick();
      if (v && rdy) k++;
      j++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    wm_enable_write = '0;
    bm_enable_write = '0;
    check("in_budget", guard < 200, 1);
    check("rdy_after_last", in_ready_a, 0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (busy_a && guard < 50) begin
      tick();
      guard++;
    end
    check("out_budget", busy_a, 0);
    out_ready = 1'b0;
  endtask

  function automatic int rnd(input int mode);
    case (mode)
      0:       return int'($urandom_range(200)) - 100;
      1:       return int'($urandom_range(65535)) - 32768;
      default: return int'($urandom_range(6000)) - 3000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int x[DEPTH];
    int mode;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    riscv_data = '0; riscv_address = '0; wm_enable_write = '0; bm_enable_write = '0;
    b_m = '{0, 0};
    #1;
    check("rst_busy", busy_a | busy_b, 0);
    check("rst_in_ready", in_ready_a | in_ready_b, 0);
    check("rst_out_valid", out_valid_a | out_valid_b, 0);
    check("rst_done", done_a | done_b, 0);
    check("rst_out_data", {out_data_a, out_data_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Basic vector, no gaps
    load_s1();
    x = '{1, 1, 1, 1};
    run_vec(x, 0, 0, 1'b0, 1'b0, 7'd0);

    // Negative input sample
    cfg_b(0, 0);
    x = '{-3, 2, 0, 1};
    run_vec(x, 0, 0, 1'b0, 1'b0, 7'd0);

    // Saturation both directions
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < DEPTH; i++) cfg_w(n, i, 32767);
      cfg_b(n, 0);
    end
    x = '{32767, 32767, 32767, 32767};
    run_vec(x, 0, 0, 1'b0, 1'b0, 7'd0);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++) cfg_w(n, i, -32768);
    run_vec(x, 0, 0, 1'b0, 1'b0, 7'd0);

    // Gapped stream, held output, stray start/config pulses while busy
    load_s1();
    x = '{1, 1, 1, 1};
    run_vec(x, 0, 5, 1'b1, 1'b1, 7'b1101001);

    // Reset after two handshakes aborts the vector
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'd1;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_busy", busy_a | busy_b, 0);
    check("abort_in_ready", in_ready_a | in_ready_b, 0);
    check("abort_out_valid", out_valid_a | out_valid_b, 0);
    check("abort_done", done_a | done_b, 0);
    check("abort_out_data", {out_data_a, out_data_b}, 0);
    b_m = '{0, 0};
    q0.delete();
    q1.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    cfg_b(0, 10);
    cfg_b(1, 5);
    run_vec(x, 0, 0, 1'b0, 1'b0, 7'd0);

    // Out-of-range address write, then config writes during RUN
    cfg_w(0, 4, 777);
    cfg_w(1, 5, -777);
    run_vec(x, 0, 0, 1'b1, 1'b0, 7'd0);

    // Randomized vectors
    for (int t = 0; t < 25; t++) begin
      mode = int'($urandom_range(2));
      for (int n = 0; n < NN; n++) begin
        for (int i = 0; i < DEPTH; i++) cfg_w(n, i, rnd(mode));
        cfg_b(n, rnd(mode));
      end
      for (int i = 0; i < DEPTH; i++) x[i] = rnd(mode);
      run_vec(x, int'($urandom_range(60)), int'($urandom_range(4)), 1'($urandom_range(1)), 1'b0, 7'd0);
    end

    repeat (3) tick();
    check("sb_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
Parametrised successor to the fixed 80-input, 10-neuron FC datapath. It computes NUM_NEURONS fully-connected outputs over an IFM_DEPTH-long streamed input vector. Weights sit in per-neuron single-port memories and biases in registers, both loaded over the RISC-V config bus. An internal FSM sequences accumulation, bias addition, fixed-point scaling/saturation and optional ReLU. The input arrives as a valid/ready stream, replacing the wide Data_in mux, and the result leaves through a held output with a valid/ready handshake.

Parameters:
DATA_WIDTH, 16, signed two's-complement width of data, weights and biases
IFM_DEPTH, 80, inputs per vector (≥2)
NUM_NEURONS, 10, parallel neurons/MACs
FRAC_BITS, 8, fractional bits of the fixed-point format
ADDRESS_BITS, 15, config address width
ACC_WIDTH, 2*DATA_WIDTH+$clog2(IFM_DEPTH)+1, accumulator width
RELU_IN, 1, apply ReLU to each input sample
RELU_OUT, 0, apply ReLU to final outputs

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
riscv_data  in  DATA_WIDTH  config write data
riscv_address  in  ADDRESS_BITS  config address (weight index)
wm_enable_write  in  NUM_NEURONS  per-neuron weight-memory write strobe
bm_enable_write  in  NUM_NEURONS  per-neuron bias write strobe
start  in  1  begin one vector computation
busy  out  1  high from accepted start until output consumed
in_valid  in  1  input sample valid
in_ready  out  1  engine accepts sample
in_data  in  DATA_WIDTH  input sample
out_valid  out  1  results valid, held until out_ready
out_ready  in  1  consumer accepts results
out_data  out  NUM_NEURONS*DATA_WIDTH  neuron n at bits [n*DW +: DW]
done  out  1  one-cycle pulse on the first out_valid cycle

Behaviour:
- Reset (reset=0, async): FSM=IDLE. busy, in_ready, out_valid, done, out_data, accumulators, bias registers, sample index → 0. Weight memory contents are not cleared.
- FSM states: IDLE → RUN → DRAIN → BIAS → OUT → IDLE.
- IDLE: config writes accepted. When wm_enable_write[n]=1 and riscv_address<IFM_DEPTH, W_n[address] is written. When bm_enable_write[n]=1, bias_n is written. Addresses ≥IFM_DEPTH are ignored. In all other states config writes are ignored.
- start=1 in IDLE: clear accumulators, idx=0, busy=1, go to RUN. in_ready rises the next cycle. start is ignored outside IDLE.
- RUN: in_ready=1. All weight memories read address idx every cycle, with 1-cycle synchronous latency.
  - Handshake (in_valid&in_ready): x_reg <= RELU_IN ? max(in_data,0) : in_data; mac_v<=1; idx++.
  - The cycle after a handshake: acc_n += x_reg*W_n (full 2*DW signed product, sign-extended to ACC_WIDTH).
  - in_valid gaps: idx and accumulators hold.
  - The handshake with idx=IFM_DEPTH-1 moves to DRAIN. in_ready=0 in every state except RUN.
- DRAIN: final MAC completes.
- BIAS: acc_n += sign-extended bias_n <<< FRAC_BITS.
- OUT entry: res = acc_n >>> FRAC_BITS (arithmetic), saturated to [-2^(DW-1), 2^(DW-1)-1], then ReLU if RELU_OUT. res is registered into out_data. out_valid=1 and done=1 for that cycle only.
- OUT: out_data and out_valid are held stable while out_ready=0. Handshake → out_valid=0, busy=0, IDLE. out_data retains its last value.
- Latency: last input handshake at cycle T → out_valid at T+3. start at cycle S → in_ready at S+1.
- Reset mid-operation aborts immediately. The partial result is discarded and no done pulse is issued.

Test Plan:
1. DW=16, FRAC_BITS=0, IFM_DEPTH=4, NUM_NEURONS=2. W0=[1,2,3,4], W1=[-1,-1,-1,-1], bias=[10,5]. Inputs [1,1,1,1], no gaps, out_ready=1 → out_data={1,20}. out_valid and done rise exactly 3 cycles after the 4th handshake; busy drops the next cycle.
2. RELU_IN=1, W0=[1,2,3,4], bias0=0, inputs [-3,2,0,1] → out0=8. With RELU_IN=0 → out0=5.
3. Saturation, FRAC_BITS=0: all weights and inputs 32767 → out=32767. Weights -32768 with inputs 32767 → -32768; with RELU_OUT=1 → 0.
4. Stream inputs with in_valid 1,0,0,1,0,1,1 and hold out_ready=0 for 5 cycles → same result as scenario 1. out_data stable with out_valid held; done high for one cycle only; start pulses during RUN/OUT ignored; in_ready=0 after the 4th handshake.
5. Assert reset after 2 handshakes → all outputs 0 immediately, busy=0. After release, with biases reloaded and start issued, scenario 1 inputs → {1,20}, since weights are retained.
6. During RUN, write W0[0]=100 and bias0=99 → ignored, result {1,20}. Write to riscv_address=4 in IDLE → no weight is modified.
